// File: rtl/bm_pkg.sv
// bm_pkg: shared constants and types for the bitmap register path
package bm_pkg;
  localparam int B = 1500;
  localparam int W = 16;
  localparam int AW = 16;
  localparam int NWORDS = (B + W - 1) / W;
  localparam int LAST_BITS = B - (NWORDS - 1) * W;
  localparam int CW = $clog2(NWORDS + 1);
  typedef enum logic [1:0] {IDLE, FETCH, COMMIT} state_e;
  localparam logic [1:0] BM0 = 2'd0;
  localparam logic [1:0] BM1 = 2'd1;
  localparam logic [1:0] BM2 = 2'd2;
endpackage

// File: rtl/bm_loader.sv
// bm_loader: fetches a bitmap image word by word and commits it to the register file in one write
module bm_loader
  import bm_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [1:0]    dst,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [W-1:0]  mem_rdata,
  input  logic          mem_valid,
  output logic          wbm,
  output logic [1:0]    wbm_addr,
  output logic [B-1:0]  wbm_data
);
  localparam logic [B-1:0] WORD_MASK = B'({W{1'b1}});
  localparam logic [B-1:0] LAST_MASK = B'({LAST_BITS{1'b1}});
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    dst_q, dst_d;
  logic          err_q, err_d;
  logic [B-1:0]  buf_q, buf_d, mask;
  logic [10:0]   off;
  logic          go, accept, last;
  assign go     = state_q == IDLE && start && dst <= BM2;
  assign accept = state_q == FETCH && mem_valid;
  assign last   = cnt_q == CW'(NWORDS - 1);
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb
    state_d = state_q == IDLE  ? (go ? FETCH : IDLE) :
              state_q == FETCH ? (accept && last ? COMMIT : FETCH) : IDLE;
  always_comb begin
    busy     = state_q != IDLE;
    mem_rd   = state_q == FETCH;
    mem_addr = mem_rd ? addr_q : '0;
    wbm      = state_q == COMMIT;
    done     = wbm;
    wbm_addr = dst_q;
    wbm_data = buf_q;
    err      = err_q;
  end
  // The final word only carries LAST_BITS payload bits; the mask drops the rest.
  always_comb begin
    off    = 11'(cnt_q) * 11'(W);
    mask   = last ? LAST_MASK : WORD_MASK;
    buf_d  = accept ? (buf_q & ~(mask << off)) | ((B'(mem_rdata) & mask) << off) : buf_q;
    cnt_d  = accept ? cnt_q + 1'b1 : (state_q == FETCH ? cnt_q : '0);
    addr_d = go ? base_addr : (accept ? addr_q + 1'b1 : addr_q);
    dst_d  = go ? dst : dst_q;
    err_d  = state_q == IDLE && start && dst > BM2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      addr_q <= '0;
      dst_q  <= '0;
      err_q  <= 1'b0;
      buf_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      dst_q  <= dst_d;
      err_q  <= err_d;
      buf_q  <= buf_d;
    end
  end
endmodule

// File: tb/tb_bm_loader.sv
// tb_bm_loader: scoreboard bench for bm_loader with a wait-state memory model
module tb_bm_loader;
  import bm_pkg::*;
  typedef struct {
    logic [1:0]   dst;
    logic [B-1:0] img;
  } commit_t;
  logic clk = 0, rst = 1, start = 0, mem_valid = 0;
  logic [AW-1:0] base_addr = '0;
  logic [1:0] dst = '0;
  logic [W-1:0] mem_rdata = '0;
  logic busy, done, err, mem_rd, wbm;
  logic [AW-1:0] mem_addr;
  logic [1:0] wbm_addr;
  logic [B-1:0] wbm_data;
  int nvec = 0, nmis = 0;
  logic [AW-1:0] addr_sb[$];
  commit_t cmt_sb[$];
  int cyc = 0, start_c = 0, wbm_c = -10, mode = 0, maxw = 0, wcnt = 0;
  int nacc = 0, ndone = 0, nerr = 0;
  logic waiting = 0;
  logic [AW-1:0] hold_addr = '0, cur_base = '0;

  bm_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .dst(dst),
    .busy(busy), .done(done), .err(err), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .wbm(wbm), .wbm_addr(wbm_addr),
    .wbm_data(wbm_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [B-1:0] got, input logic [B-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] word(input int k);
    return mode == 1 ? (k == NWORDS - 1 ? 16'hFFFF : 16'h0000) : 16'h1000 + W'(k);
  endfunction

  // Memory model: random stalls while a read is pending, noise on mem_valid otherwise.
  always @(negedge clk) begin
    logic [AW-1:0] ea;
    commit_t c;
    if (err) nerr++;
    if (done) ndone++;
    if (cyc == wbm_c + 1) begin
      chk("busy_after", B'(busy), B'(0));
      chk("wbm_after", B'(wbm), B'(0));
    end
    if (wbm || done) begin
      chk("done_wbm", B'(done), B'(wbm));
      if (cmt_sb.size() == 0) chk("unexp_wbm", B'(wbm), B'(0));
      else begin
        c = cmt_sb.pop_front();
        chk("wbm_addr", B'(wbm_addr), B'(c.dst));
        chk("image", wbm_data, c.img);
        if (maxw == 0) chk("latency", B'(cyc - start_c), B'(NWORDS + 1));
        wbm_c = cyc;
      end
    end
    if (mem_rd) begin
      if (waiting) chk("hold", B'(mem_addr), B'(hold_addr));
      if (wcnt > 0) begin
        wcnt--;
        waiting = 1;
        hold_addr = mem_addr;
        mem_valid = 0;
        mem_rdata = W'($urandom);
      end else begin
        waiting = 0;
        mem_valid = 1;
        nacc++;
        if (addr_sb.size() == 0) begin
          chk("unexp_rd", B'(mem_rd), B'(0));
          mem_rdata = '0;
        end else begin
          ea = addr_sb.pop_front();
          chk("mem_addr", B'(mem_addr), B'(ea));
          mem_rdata = word(int'(ea - cur_base));
        end
        wcnt = maxw > 0 ? $urandom_range(maxw, 0) : 0;
      end
    end else begin
      waiting = 0;
      wcnt = maxw > 0 ? $urandom_range(maxw, 0) : 0;
      mem_valid = 1'($urandom);
      mem_rdata = W'($urandom);
    end
  end

  task automatic expect_load(input logic [AW-1:0] b, input logic [1:0] d);
    commit_t c;
    logic [W-1:0] lw;
    c.dst = d;
    c.img = '0;
    for (int k = 0; k < NWORDS; k++) addr_sb.push_back(b + AW'(k));
    for (int k = 0; k < NWORDS - 1; k++) c.img[k*W +: W] = word(k);
    lw = word(NWORDS - 1);
    c.img[B-1 -: LAST_BITS] = lw[LAST_BITS-1:0];
    cmt_sb.push_back(c);
  endtask

  task automatic load(input logic [AW-1:0] b, input logic [1:0] d, input int md, input int mw, input int inj);
    int d0, e0;
    mode = md;
    maxw = mw;
    cur_base = b;
    @(negedge clk);
    expect_load(b, d);
    d0 = ndone;
    e0 = nerr;
    start = 1;
    base_addr = b;
    dst = d;
    start_c = cyc;
    @(negedge clk);
    start = 0;
    chk("rd_c1", B'(mem_rd), B'(1));
    chk("busy_c1", B'(busy), B'(1));
    if (inj > 0) begin
      repeat (inj) @(negedge clk);
      start = 1;
      dst = 2'd3;
      base_addr = 16'h1234;
      @(negedge clk);
      start = 0;
    end
    for (int t = 0; t < 2000 && ndone == d0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("done_cnt", B'(ndone - d0), B'(1));
    chk("err_cnt", B'(nerr - e0), B'(0));
    chk("sb_empty", B'(addr_sb.size() + cmt_sb.size()), B'(0));
  endtask

  initial begin
    int e0, a0, d0;
    repeat (3) @(negedge clk);
    chk("rst_busy", B'(busy), B'(0));
    chk("rst_done", B'(done), B'(0));
    chk("rst_err", B'(err), B'(0));
    chk("rst_rd", B'(mem_rd), B'(0));
    chk("rst_addr", B'(mem_addr), B'(0));
    chk("rst_wbm", B'(wbm), B'(0));
    chk("rst_wbm_addr", B'(wbm_addr), B'(0));
    chk("rst_data", wbm_data, '0);
    rst = 0;
    load(16'h0200, BM1, 0, 0, 0);
    chk("w0", B'(wbm_data[15:0]), B'(16'h1000));
    chk("wlast", B'(wbm_data[B-1 -: LAST_BITS]), B'(12'h05D));
    load(16'h0000, BM2, 1, 0, 0);
    chk("trunc_hi", B'(wbm_data[B-1 -: LAST_BITS]), B'(12'hFFF));
    chk("trunc_lo", B'(wbm_data[B-LAST_BITS-1:0]), '0);
    load(16'h0200, BM0, 0, 3, 0);
    load(16'hFFF0, BM1, 0, 0, 0);
    @(negedge clk);
    e0 = nerr;
    start = 1;
    dst = 2'd3;
    base_addr = 16'h4000;
    @(negedge clk);
    start = 0;
    chk("err_pulse", B'(err), B'(1));
    chk("rej_rd", B'(mem_rd | busy), B'(0));
    @(negedge clk);
    chk("err_once", B'(err), B'(0));
    chk("rej_rd2", B'(mem_rd | busy), B'(0));
    load(16'h0500, BM2, 0, 0, 30);
    mode = 0;
    maxw = 0;
    cur_base = 16'h0300;
    @(negedge clk);
    expect_load(16'h0300, BM2);
    a0 = nacc;
    start = 1;
    base_addr = 16'h0300;
    dst = BM2;
    @(negedge clk);
    start = 0;
    for (int t = 0; t < 500 && nacc - a0 < 40; t++) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mid_busy", B'(busy), B'(0));
    chk("mid_rd", B'(mem_rd), B'(0));
    chk("mid_wbm", B'(wbm | done), B'(0));
    chk("mid_data", wbm_data, '0);
    addr_sb.delete();
    cmt_sb.delete();
    rst = 0;
    d0 = ndone;
    repeat (120) @(negedge clk);
    chk("no_commit", B'(ndone - d0), B'(0));
    load(16'h0200, BM0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
